// File: rtl/audio_dsm_output_multi.sv
// N-channel PCM frame FIFO feeding one first-order delta-sigma modulator per channel.
// Frames are popped once per programmable sample period; the FIFO read path is registered.
module audio_dsm_output_multi #(
  parameter int CHANNELS           = 2,
  parameter int SAMPLE_WIDTH       = 16,
  parameter int FIFO_DEPTH_IN_BITS = 4,
  parameter int DIVIDER_WIDTH      = 16,
  parameter int SIGNED_INPUT       = 0,
  parameter int UNDERRUN_MUTE      = 0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [CHANNELS*SAMPLE_WIDTH-1:0]   data,
  input  logic                               valid,
  output logic                               ready,
  input  logic [DIVIDER_WIDTH-1:0]           clock_divider,
  input  logic                               enable,
  output logic [FIFO_DEPTH_IN_BITS:0]        fifo_level,
  output logic                               underrun,
  input  logic                               underrun_clear,
  output logic [CHANNELS-1:0]                dsm_out
);

  localparam int FRAME_W = CHANNELS * SAMPLE_WIDTH;
  localparam int DEPTH   = 1 << FIFO_DEPTH_IN_BITS;
  localparam logic [FIFO_DEPTH_IN_BITS:0] FULL     = {1'b1, {FIFO_DEPTH_IN_BITS{1'b0}}};
  localparam logic [SAMPLE_WIDTH-1:0]     MIDSCALE = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

  function automatic logic [SAMPLE_WIDTH-1:0] to_offset_binary(input logic [SAMPLE_WIDTH-1:0] s);
    if (SIGNED_INPUT != 0) return {~s[SAMPLE_WIDTH-1], s[SAMPLE_WIDTH-2:0]};
    return s;
  endfunction

  logic [FRAME_W-1:0]            mem [DEPTH];
  logic [FIFO_DEPTH_IN_BITS-1:0] wr_ptr;
  logic [FIFO_DEPTH_IN_BITS-1:0] rd_ptr;
  logic [DIVIDER_WIDTH-1:0]      period_cnt;

  logic tick_p0;
  logic push_p0;
  logic pop_p0;
  logic starve_p0;

  logic [FRAME_W-1:0]      rd_frame_p1;
  logic                    vld_p1;
  logic                    starve_p1;

  logic [SAMPLE_WIDTH-1:0] sample_p2 [CHANNELS];
  logic [SAMPLE_WIDTH:0]   acc_p2    [CHANNELS];

  assign ready     = (fifo_level < FULL);
  assign tick_p0   = enable && (period_cnt == '0);
  assign push_p0   = valid && ready;
  assign pop_p0    = tick_p0 && (fifo_level != '0);
  assign starve_p0 = tick_p0 && (fifo_level == '0);

  // stage p0 -> p1: FIFO storage write and registered read of the popped frame
  always_ff @(posedge clk) begin
    if (push_p0) mem[wr_ptr] <= data;
    if (pop_p0)  rd_frame_p1 <= mem[rd_ptr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      period_cnt <= '0;
      underrun   <= 1'b0;
      vld_p1     <= 1'b0;
      starve_p1  <= 1'b0;
    end else begin
      if (push_p0) wr_ptr <= wr_ptr + 1'b1;
      if (pop_p0)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_p0, pop_p0})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      if (!enable || period_cnt == '0) period_cnt <= clock_divider;
      else                             period_cnt <= period_cnt - 1'b1;
      if (starve_p0)           underrun <= 1'b1;
      else if (underrun_clear) underrun <= 1'b0;
      vld_p1    <= pop_p0;
      starve_p1 <= starve_p0;
    end
  end

  // stage p1 -> p2: sample capture and per-channel first-order modulator
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        sample_p2[c] <= MIDSCALE;
        acc_p2[c]    <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        acc_p2[c] <= {1'b0, acc_p2[c][SAMPLE_WIDTH-1:0]} + {1'b0, sample_p2[c]};
        if (vld_p1)
          sample_p2[c] <= to_offset_binary(rd_frame_p1[c*SAMPLE_WIDTH +: SAMPLE_WIDTH]);
        else if (starve_p1 && (UNDERRUN_MUTE != 0))
          sample_p2[c] <= MIDSCALE;
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_out
    assign dsm_out[c] = acc_p2[c][SAMPLE_WIDTH];
  end

endmodule

// File: tb/tb_audio_dsm_output_multi.sv
// Bench for audio_dsm_output_multi: two instances (unsigned/hold and signed/mute) share stimulus
// and are compared every cycle against a queue-based frame model, plus literal density counts.
module tb_audio_dsm_output_multi;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] data = '0;
  logic        valid = 1'b0;
  logic [15:0] clock_divider = '0;
  logic        enable = 1'b0;
  logic        underrun_clear = 1'b0;

  logic       ready0, ready1, underrun0, underrun1;
  logic [4:0] level0, level1;
  logic [1:0] dsm0, dsm1;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;
  int ones [2][2];

  always #5 clk = ~clk;

  audio_dsm_output_multi u0 (
    .clk(clk), .reset(reset), .data(data), .valid(valid), .ready(ready0),
    .clock_divider(clock_divider), .enable(enable), .fifo_level(level0),
    .underrun(underrun0), .underrun_clear(underrun_clear), .dsm_out(dsm0)
  );

  audio_dsm_output_multi #(.SIGNED_INPUT(1), .UNDERRUN_MUTE(1)) u1 (
    .clk(clk), .reset(reset), .data(data), .valid(valid), .ready(ready1),
    .clock_divider(clock_divider), .enable(enable), .fifo_level(level1),
    .underrun(underrun1), .underrun_clear(underrun_clear), .dsm_out(dsm1)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: frames in a queue, samples and accumulators as plain integers.
  logic [31:0] mq[$];
  logic [31:0] pend_frame;
  bit          pend_pop, pend_starve, m_ur, m_tick, m_push, m_pop;
  int          m_cnt, m_v;
  int          m_s   [2][2];
  int          m_acc [2][2];
  bit [1:0]    m_dsm [2];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_cnt = 0; m_ur = 0; pend_pop = 0; pend_starve = 0;
      for (int k = 0; k < 2; k++) begin
        m_dsm[k] = 2'b00;
        for (int c = 0; c < 2; c++) begin m_s[k][c] = 32768; m_acc[k][c] = 0; end
      end
    end else begin
      m_tick = enable && (m_cnt == 0);
      m_push = valid && (mq.size() < 16);
      m_pop  = m_tick && (mq.size() > 0);
      for (int k = 0; k < 2; k++)
        for (int c = 0; c < 2; c++) begin
          m_acc[k][c] = (m_acc[k][c] % 65536) + m_s[k][c];
          m_dsm[k][c] = (m_acc[k][c] >= 65536);
          if (pend_pop) begin
            m_v = int'(pend_frame[c*16 +: 16]);
            if (k == 1) m_v = m_v ^ 32768;
            m_s[k][c] = m_v;
          end else if (pend_starve && k == 1) begin
            m_s[k][c] = 32768;
          end
        end
      pend_pop    = m_pop;
      pend_starve = m_tick && !m_pop;
      if (m_pop) pend_frame = mq.pop_front();
      if (m_push) mq.push_back(data);
      if (m_tick && !m_pop) m_ur = 1;
      else if (underrun_clear) m_ur = 0;
      if (!enable || m_cnt == 0) m_cnt = int'(clock_divider);
      else m_cnt = m_cnt - 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_level0", int'(level0), mq.size());
      chk("m_level1", int'(level1), mq.size());
      chk("m_ready0", int'(ready0), int'(mq.size() < 16));
      chk("m_ready1", int'(ready1), int'(mq.size() < 16));
      chk("m_underrun0", int'(underrun0), int'(m_ur));
      chk("m_underrun1", int'(underrun1), int'(m_ur));
      chk("m_dsm0", int'(dsm0), int'(m_dsm[0]));
      chk("m_dsm1", int'(dsm1), int'(m_dsm[1]));
    end
  end

  task automatic count_ones(input int n);
    for (int k = 0; k < 2; k++) for (int c = 0; c < 2; c++) ones[k][c] = 0;
    repeat (n) begin
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        ones[0][c] += int'(dsm0[c]);
        ones[1][c] += int'(dsm1[c]);
      end
    end
  endtask

  initial begin
    #3 reset = 1'b1;
    #1 chk_en = 1'b1;
    chk("rst_ready", int'(ready0), 1);
    chk("rst_level", int'(level0), 0);
    chk("rst_underrun", int'(underrun0), 0);
    chk("rst_dsm", int'(dsm0), 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Idle at midscale: both channels alternate 0,1 starting with 0
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("idle_dsm0", int'(dsm0), (i % 2) ? 3 : 0);
      chk("idle_dsm1", int'(dsm1), (i % 2) ? 3 : 0);
    end

    // Fill the FIFO with enable low, then offer one extra frame
    for (int i = 0; i < 16; i++) begin
      data  = {16'(16'h1000 + i * 273), 16'(16'h2000 + i * 801)};
      valid = 1'b1;
      @(negedge clk);
    end
    chk("full_level", int'(level0), 16);
    chk("full_ready", int'(ready0), 0);
    data = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("drop_level", int'(level0), 16);
    valid = 1'b0;

    // Drain every cycle until starved
    clock_divider = 16'd0;
    enable = 1'b1;
    repeat (20) @(negedge clk);
    enable = 1'b0;
    chk("drain_level", int'(level0), 0);
    chk("drain_underrun", int'(underrun0), 1);
    underrun_clear = 1'b1;
    @(negedge clk);
    underrun_clear = 1'b0;
    chk("clear_underrun0", int'(underrun0), 0);
    chk("clear_underrun1", int'(underrun1), 0);

    // Density: L=0xC000, R=0x4000, period 4
    data  = {16'h4000, 16'hC000};
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    clock_divider = 16'd3;
    enable = 1'b1;
    repeat (10) @(negedge clk);
    count_ones(256);
    chk("dens_l", ones[0][0], 192);
    chk("dens_r", ones[0][1], 64);

    // Single pop of L=0x0000, R=0x8000
    enable = 1'b0;
    clock_divider = 16'd0;
    underrun_clear = 1'b1;
    data  = {16'h8000, 16'h0000};
    valid = 1'b1;
    @(negedge clk);
    underrun_clear = 1'b0;
    valid = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    repeat (4) @(negedge clk);
    count_ones(256);
    chk("signed_l", ones[1][0], 128);
    chk("signed_r", ones[1][1], 0);
    chk("unsigned_l", ones[0][0], 0);
    chk("unsigned_r", ones[0][1], 128);
    chk("one_pop_no_underrun", int'(underrun0), 0);

    // Empty tick coinciding with clear: set wins
    enable = 1'b1;
    underrun_clear = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    underrun_clear = 1'b0;
    chk("set_wins0", int'(underrun0), 1);
    chk("set_wins1", int'(underrun1), 1);
    @(negedge clk);
    chk("sticky", int'(underrun0), 1);
    repeat (3) @(negedge clk);
    count_ones(256);
    chk("mute_l", ones[1][0], 128);
    chk("mute_r", ones[1][1], 128);
    chk("hold_l", ones[0][0], 0);
    chk("hold_r", ones[0][1], 128);

    // Steady level with push and pop every cycle, then reset mid-stream
    for (int i = 0; i < 8; i++) begin
      data  = {16'(16'h3000 + i * 4099), 16'(16'h0100 + i * 1234)};
      valid = 1'b1;
      @(negedge clk);
    end
    valid = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 20 && mq.size() != 5; i++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      data  = {16'(16'hA000 + i * 777), 16'(16'h5000 + i * 333)};
      valid = 1'b1;
      @(negedge clk);
      chk("hold5_level", int'(level0), 5);
    end
    #2 reset = 1'b1;
    #1;
    chk("arst_dsm0", int'(dsm0), 0);
    chk("arst_dsm1", int'(dsm1), 0);
    chk("arst_level", int'(level0), 0);
    chk("arst_ready", int'(ready0), 1);
    chk("arst_underrun", int'(underrun0), 0);
    @(negedge clk);
    reset = 1'b0;
    valid = 1'b0;
    enable = 1'b0;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
